instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch.sv | 135 +++++++++++++
 tb/tb_instruction_fetch.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: an 8-bit word PC, a single-outstanding memory request and a one-entry skid register.
// The optional halt-on-0xFFFFFFFF detection is enabled by defining IF_HALT_DETECT_EN.
module instruction_fetch (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_IF,
  input  logic        enableDebug,
  input  logic        redirect_valid,
  input  logic [7:0]  redirect_pc,
  output logic        imem_req,
  output logic [7:0]  imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_data,
  output logic [7:0]  programCounter_out,
  output logic [31:0] instruction_out,
  output logic        instr_valid,
  output logic        clear_out,
  output logic        halted
);

`ifdef IF_HALT_DETECT_EN
  typedef enum logic [1:0] {S_FETCH, S_DISCARD, S_HALT} state_t;
`else
  typedef enum logic [1:0] {S_FETCH, S_DISCARD} state_t;
`endif

  state_t      r_state;
  logic [7:0]  r_pc;
  logic        r_outstanding;
  logic [7:0]  r_req_addr;
  logic [31:0] r_skid_data;
  logic [7:0]  r_skid_pc;
  logic        r_skid_valid;
  logic [7:0]  r_pc_out;
  logic [31:0] r_instr_out;
  logic        r_instr_valid;
  logic        r_clear;

  logic        w_able;
  logic        w_start;
  logic        w_fire;
  logic [7:0]  w_pc_inc;

  assign w_able   = ~stall_IF & enableDebug;
  assign w_start  = (r_state == S_FETCH) & w_able & ~r_skid_valid & ~redirect_valid & ~r_outstanding;
  // Gating with reset keeps the request low while reset is held, even though FETCH is the reset state.
  assign imem_req  = reset & (r_outstanding | w_start);
  assign imem_addr = r_outstanding ? r_req_addr : r_pc;
  assign w_fire    = imem_req & imem_ready;
  assign w_pc_inc  = r_pc + 8'd1;

  assign programCounter_out = r_pc_out;
  assign instruction_out    = r_instr_out;
  assign instr_valid        = r_instr_valid;
  assign clear_out          = r_clear;

`ifdef IF_HALT_DETECT_EN
  assign halted = (r_state == S_HALT);
`else
  assign halted = 1'b0;
`endif

  // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= S_FETCH;
      r_pc          <= 8'h00;
      r_outstanding <= 1'b0;
      r_req_addr    <= 8'h00;
      // NOTE: the skid payload is a single register, so it is reset along with its valid bit.
      r_skid_data   <= 32'h0;
      r_skid_pc     <= 8'h00;
      r_skid_valid  <= 1'b0;
      r_pc_out      <= 8'h00;
      r_instr_out   <= 32'h0;
      r_instr_valid <= 1'b0;
      r_clear       <= 1'b0;
    end else begin
      r_outstanding <= imem_req & ~imem_ready;
      if (imem_req & ~imem_ready) r_req_addr <= imem_addr;
      r_clear <= redirect_valid;

      if (redirect_valid) begin
        r_pc          <= redirect_pc;
        r_skid_valid  <= 1'b0;
        r_instr_valid <= 1'b0;
        r_state       <= (r_outstanding & ~imem_ready) ? S_DISCARD : S_FETCH;
      end else begin
        case (r_state)
          S_FETCH: begin
            if (r_skid_valid) begin
              if (w_able) begin
                r_pc_out      <= r_skid_pc;
                r_instr_out   <= r_skid_data;
                r_instr_valid <= 1'b1;
                r_skid_valid  <= 1'b0;
`ifdef IF_HALT_DETECT_EN
                if (r_skid_data == 32'hFFFF_FFFF) r_state <= S_HALT;
`endif
              end
            end else if (w_fire) begin
              r_pc <= w_pc_inc;
              if (w_able) begin
                r_pc_out      <= w_pc_inc;
                r_instr_out   <= imem_data;
                r_instr_valid <= 1'b1;
`ifdef IF_HALT_DETECT_EN
                if (imem_data == 32'hFFFF_FFFF) r_state <= S_HALT;
`endif
              end else begin
                r_skid_pc    <= w_pc_inc;
                r_skid_data  <= imem_data;
                r_skid_valid <= 1'b1;
              end
            end else if (w_able) begin
              r_instr_valid <= 1'b0;
            end
          end
          S_DISCARD: begin
            // The late response belongs to a squashed path; it only closes the request.
            if (imem_ready) r_state <= S_FETCH;
            if (w_able) r_instr_valid <= 1'b0;
          end
`ifdef IF_HALT_DETECT_EN
          S_HALT: begin
            if (w_able) r_instr_valid <= 1'b0;
          end
`endif
          default: r_state <= S_FETCH;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: a vector table on a zero-wait ROM (word n = n),
// then hand-sequenced stall/skid, redirect/discard, wrap and halt corner cases on a manually driven memory.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall_IF = 1'b0;
  logic        enableDebug = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [7:0]  redirect_pc = 8'h00;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ready;
  logic [31:0] imem_data;
  logic [7:0]  programCounter_out;
  logic [31:0] instruction_out;
  logic        instr_valid;
  logic        clear_out;
  logic        halted;

  logic        zw = 1'b1;
  logic        hw_en = 1'b0;
  logic        man_ready = 1'b0;
  logic [31:0] man_data = 32'h0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign imem_ready = zw ? imem_req : man_ready;
  assign imem_data  = zw ? ((hw_en && imem_addr == 8'h03) ? 32'hFFFF_FFFF : {24'h0, imem_addr}) : man_data;

  instruction_fetch dut (
    .clk                (clk),
    .reset              (reset),
    .stall_IF           (stall_IF),
    .enableDebug        (enableDebug),
    .redirect_valid     (redirect_valid),
    .redirect_pc        (redirect_pc),
    .imem_req           (imem_req),
    .imem_addr          (imem_addr),
    .imem_ready         (imem_ready),
    .imem_data          (imem_data),
    .programCounter_out (programCounter_out),
    .instruction_out    (instruction_out),
    .instr_valid        (instr_valid),
    .clear_out          (clear_out),
    .halted             (halted)
  );

  typedef struct {
    logic        st;
    logic        en;
    logic        rv;
    logic [7:0]  rpc;
    logic        req;
    logic [7:0]  addr;
    logic [7:0]  pc;
    logic [31:0] ins;
    logic        vld;
    logic        clr;
  } vec_t;

  vec_t tbl [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, check the request seen during the cycle, clock, then check the registered outputs.
  task automatic step(input string nm, input logic st, input logic en, input logic rv, input logic [7:0] rpc,
                      input logic rdy, input logic [31:0] dat,
                      input logic e_req, input logic [7:0] e_addr,
                      input logic [7:0] e_pc, input logic [31:0] e_ins, input logic e_vld, input logic e_clr);
    stall_IF       = st;
    enableDebug    = en;
    redirect_valid = rv;
    redirect_pc    = rpc;
    man_ready      = rdy;
    man_data       = dat;
    #1;
    check({nm, ".req"},  {31'h0, imem_req}, {31'h0, e_req});
    check({nm, ".addr"}, {24'h0, imem_addr}, {24'h0, e_addr});
    @(posedge clk);
    #1;
    check({nm, ".pc_out"}, {24'h0, programCounter_out}, {24'h0, e_pc});
    check({nm, ".instr"},  instruction_out, e_ins);
    check({nm, ".valid"},  {31'h0, instr_valid}, {31'h0, e_vld});
    check({nm, ".clear"},  {31'h0, clear_out}, {31'h0, e_clr});
  endtask

  initial begin
    //          st  en  rv  rpc    req addr   pc     ins            vld clr
    tbl[0]  = '{0, 1, 0, 8'h00, 1, 8'h00, 8'h01, 32'h0000_0000, 1, 0};
    tbl[1]  = '{0, 1, 0, 8'h00, 1, 8'h01, 8'h02, 32'h0000_0001, 1, 0};
    tbl[2]  = '{0, 1, 0, 8'h00, 1, 8'h02, 8'h03, 32'h0000_0002, 1, 0};
    tbl[3]  = '{1, 1, 0, 8'h00, 0, 8'h03, 8'h03, 32'h0000_0002, 1, 0};
    tbl[4]  = '{0, 0, 0, 8'h00, 0, 8'h03, 8'h03, 32'h0000_0002, 1, 0};
    tbl[5]  = '{0, 1, 0, 8'h00, 1, 8'h03, 8'h04, 32'h0000_0003, 1, 0};
    tbl[6]  = '{0, 1, 1, 8'hFF, 0, 8'h04, 8'h04, 32'h0000_0003, 0, 1};
    tbl[7]  = '{0, 1, 0, 8'h00, 1, 8'hFF, 8'h00, 32'h0000_00FF, 1, 0};
    tbl[8]  = '{0, 1, 0, 8'h00, 1, 8'h00, 8'h01, 32'h0000_0000, 1, 0};
    tbl[9]  = '{1, 1, 1, 8'h10, 0, 8'h01, 8'h01, 32'h0000_0000, 0, 1};
    tbl[10] = '{1, 1, 0, 8'h00, 0, 8'h10, 8'h01, 32'h0000_0000, 0, 0};
    tbl[11] = '{0, 1, 0, 8'h00, 1, 8'h10, 8'h11, 32'h0000_0010, 1, 0};
    tbl[12] = '{0, 0, 1, 8'h40, 0, 8'h11, 8'h11, 32'h0000_0010, 0, 1};
    tbl[13] = '{0, 1, 0, 8'h00, 1, 8'h40, 8'h41, 32'h0000_0040, 1, 0};

    // Reset state
    #1;
    check("rst.req",    {31'h0, imem_req}, 32'h0);
    check("rst.pc_out", {24'h0, programCounter_out}, 32'h0);
    check("rst.instr",  instruction_out, 32'h0);
    check("rst.valid",  {31'h0, instr_valid}, 32'h0);
    check("rst.clear",  {31'h0, clear_out}, 32'h0);
    check("rst.halted", {31'h0, halted}, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Zero-wait streaming, stall/enable hold, redirect priority and 0xFF wrap
    for (int i = 0; i < 14; i++) begin
      step($sformatf("vec%0d", i), tbl[i].st, tbl[i].en, tbl[i].rv, tbl[i].rpc, 1'b0, 32'h0,
           tbl[i].req, tbl[i].addr, tbl[i].pc, tbl[i].ins, tbl[i].vld, tbl[i].clr);
    end

    // Response to addr 5 lands in the skid while stalled, replayed on release
    step("skid_redir", 0, 1, 1, 8'h05, 0, 32'h0, 0, 8'h41, 8'h41, 32'h0000_0040, 0, 1);
    zw = 1'b0;
    step("skid_req",   0, 1, 0, 8'h00, 0, 32'h0,         1, 8'h05, 8'h41, 32'h0000_0040, 0, 0);
    step("skid_fill",  1, 1, 0, 8'h00, 1, 32'hC0DE_0005, 1, 8'h05, 8'h41, 32'h0000_0040, 0, 0);
    step("skid_hold1", 1, 1, 0, 8'h00, 0, 32'h0,         0, 8'h06, 8'h41, 32'h0000_0040, 0, 0);
    step("skid_hold2", 1, 1, 0, 8'h00, 0, 32'h0,         0, 8'h06, 8'h41, 32'h0000_0040, 0, 0);
    step("skid_drain", 0, 1, 0, 8'h00, 0, 32'h0,         0, 8'h06, 8'h06, 32'hC0DE_0005, 1, 0);
    step("skid_next",  0, 1, 0, 8'h00, 0, 32'h0,         1, 8'h06, 8'h06, 32'hC0DE_0005, 0, 0);
    step("skid_done",  0, 1, 0, 8'h00, 1, 32'hC0DE_0006, 1, 8'h06, 8'h07, 32'hC0DE_0006, 1, 0);

    // Redirect while the addr-4 request waits three cycles: response dropped, then fetch 0x20
    step("disc_redir0", 0, 1, 1, 8'h04, 0, 32'h0,         0, 8'h07, 8'h07, 32'hC0DE_0006, 0, 1);
    step("disc_req",    0, 1, 0, 8'h00, 0, 32'h0,         1, 8'h04, 8'h07, 32'hC0DE_0006, 0, 0);
    step("disc_redir",  0, 1, 1, 8'h20, 0, 32'h0,         1, 8'h04, 8'h07, 32'hC0DE_0006, 0, 1);
    step("disc_wait",   0, 1, 0, 8'h00, 0, 32'h0,         1, 8'h04, 8'h07, 32'hC0DE_0006, 0, 0);
    step("disc_drop",   0, 1, 0, 8'h00, 1, 32'hBAD0_0004, 1, 8'h04, 8'h07, 32'hC0DE_0006, 0, 0);
    step("disc_after",  0, 1, 0, 8'h00, 0, 32'h0,         1, 8'h20, 8'h07, 32'hC0DE_0006, 0, 0);

    // Redirect coinciding with the response: dropped, no discard phase
    step("same_redir",  0, 1, 1, 8'h50, 1, 32'hBAD0_0020, 1, 8'h20, 8'h07, 32'hC0DE_0006, 0, 1);
    step("same_after",  0, 1, 0, 8'h00, 0, 32'h0,         1, 8'h50, 8'h07, 32'hC0DE_0006, 0, 0);

    // Back-to-back redirects during discard: newest target wins
    step("rr_first",    0, 1, 1, 8'h60, 0, 32'h0,         1, 8'h50, 8'h07, 32'hC0DE_0006, 0, 1);
    step("rr_second",   0, 1, 1, 8'h70, 0, 32'h0,         1, 8'h50, 8'h07, 32'hC0DE_0006, 0, 1);
    step("rr_drop",     0, 1, 0, 8'h00, 1, 32'hBAD0_0050, 1, 8'h50, 8'h07, 32'hC0DE_0006, 0, 0);
    step("rr_fetch",    0, 1, 0, 8'h00, 1, 32'h0000_7070, 1, 8'h70, 8'h71, 32'h0000_7070, 1, 0);

    // All-ones word at addr 3
    zw    = 1'b1;
    hw_en = 1'b1;
    step("ff_redir",    0, 1, 1, 8'h03, 0, 32'h0, 0, 8'h71, 8'h71, 32'h0000_7070, 0, 1);
    step("ff_fetch",    0, 1, 0, 8'h00, 0, 32'h0, 1, 8'h03, 8'h04, 32'hFFFF_FFFF, 1, 0);
`ifdef IF_HALT_DETECT_EN
    check("halt.enter", {31'h0, halted}, 32'h1);
    for (int i = 0; i < 10; i++) begin
      step($sformatf("halt_hold%0d", i), 0, 1, 0, 8'h00, 0, 32'h0, 0, 8'h04, 8'h04, 32'hFFFF_FFFF, 0, 0);
      check($sformatf("halt_hold%0d.halted", i), {31'h0, halted}, 32'h1);
    end
    step("halt_redir",  0, 1, 1, 8'h00, 0, 32'h0, 0, 8'h04, 8'h04, 32'hFFFF_FFFF, 0, 1);
    check("halt.exit", {31'h0, halted}, 32'h0);
    step("halt_resume", 0, 1, 0, 8'h00, 0, 32'h0, 1, 8'h00, 8'h01, 32'h0000_0000, 1, 0);
`else
    check("ff.halted", {31'h0, halted}, 32'h0);
    step("ff_next",     0, 1, 0, 8'h00, 0, 32'h0, 1, 8'h04, 8'h05, 32'h0000_0004, 1, 0);
    check("ff_next.halted", {31'h0, halted}, 32'h0);
`endif

    // Asynchronous reset mid-cycle
    #2;
    reset = 1'b0;
    #1;
    check("arst.req",    {31'h0, imem_req}, 32'h0);
    check("arst.pc_out", {24'h0, programCounter_out}, 32'h0);
    check("arst.instr",  instruction_out, 32'h0);
    check("arst.valid",  {31'h0, instr_valid}, 32'h0);
    check("arst.addr",   {24'h0, imem_addr}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
